// File: rtl/instr_decode_stage.sv
// ---------------------------------------------------------------------------
// instr_decode_stage
//
// Registered instruction decode stage with a register scoreboard. Sits
// between fetch and execute. A 32-bit instruction is split into opcode,
// source pair (rs_rt) and write destination (rwd) and held in an output
// register behind a valid/ready handshake. A 32-entry scoreboard tracks
// registers with writes in flight. Issue stalls on read-after-write hazards,
// and also on write-after-write hazards when WAW_CHECK=1.
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid and ready are both 1. The producer keeps its data stable while
// valid=1 and ready=0. Ready may depend combinationally on the data offered.
//
// Parameters:
//   WB_PORTS  - number of write-back clear ports (1..4)
//   CNT_W     - width of the saturating stall-cycle counter
//   WAW_CHECK - 1: also stall when the destination is busy; 0: RAW only
//
// Optional feature macro: DECODE_FLUSH_EN
//   When defined, adds input 'flush'. flush=1 at an edge drops the held
//   instruction, clears the scoreboard and blocks accept. The stall counter
//   is not affected.
//
// Ports:
//   clk, rst         - clock (rising edge), asynchronous active-high reset
//   in_valid/ready   - fetch side handshake, instr_in is the offered word
//   out_valid/ready  - execute side handshake
//   opcode           - instr_out[31:26]
//   rs_rt            - [9:5] source A, [4:0] source B
//   rwd              - destination register, 0 = no write
//   instr_out        - registered instruction word
//   wb_valid/wb_addr - per-port write-back clear, port i at wb_addr[5i+4:5i]
//   busy_vec         - scoreboard, bit r set = write to r pending
//   stall_cnt        - cycles with in_valid=1 and a hazard, saturating
// ---------------------------------------------------------------------------
module instr_decode_stage #(
  parameter int WB_PORTS  = 2,
  parameter int CNT_W     = 16,
  parameter int WAW_CHECK = 1
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef DECODE_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [5:0]            opcode,
  output logic [9:0]            rs_rt,
  output logic [4:0]            rwd,
  output logic [31:0]           instr_out,
  input  logic [WB_PORTS-1:0]   wb_valid,
  input  logic [5*WB_PORTS-1:0] wb_addr,
  output logic [31:0]           busy_vec,
  output logic [CNT_W-1:0]      stall_cnt
);

  // Opcode encodings shared with the rest of the pipeline.
  localparam logic [5:0] OP_JUMP = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_LDW  = 6'h23;
  localparam logic [5:0] OP_SDW  = 6'h2B;

  localparam bit               WAW_EN  = (WAW_CHECK != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  logic             out_valid_q, out_valid_d;
  logic [5:0]       opcode_q,    opcode_d;
  logic [9:0]       rs_rt_q,     rs_rt_d;
  logic [4:0]       rwd_q,       rwd_d;
  logic [31:0]      instr_q,     instr_d;
  logic [31:0]      busy_q,      busy_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // -------------------------------------------------------------------------
  // Flush source
  // -------------------------------------------------------------------------
  logic flush_w;
`ifdef DECODE_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Field decode on the offered instruction
  // -------------------------------------------------------------------------
  logic [5:0] dec_op;
  logic [4:0] dec_src_a;
  logic [4:0] dec_src_b;
  logic [4:0] dec_dst;

  always_comb begin
    dec_op    = instr_in[31:26];
    dec_src_a = instr_in[20:16];
    dec_src_b = instr_in[15:11];
    dec_dst   = instr_in[25:21];
    unique case (dec_op)
      OP_JUMP: begin
        dec_src_b = 5'd0;
        dec_dst   = 5'd0;
      end
      OP_SDW, OP_BEQ: begin
        dec_src_b = instr_in[25:21];
        dec_dst   = 5'd0;
      end
      OP_LDW: begin
        dec_src_b = instr_in[25:21];
      end
      default: begin
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Write-back clears and hazard detection
  // -------------------------------------------------------------------------
  // Registers being written back this cycle are treated as already free, so
  // a dependent instruction can issue in the same cycle as the write-back.
  logic [31:0] clr_mask;
  logic [31:0] eff_busy;
  logic        hazard;

  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < WB_PORTS; i++) begin
      if (wb_valid[i]) begin
        clr_mask[wb_addr[5*i +: 5]] = 1'b1;
      end
    end
  end

  // busy_q[0] is never set, so register 0 can never cause a hazard.
  assign eff_busy = busy_q & ~clr_mask;

  assign hazard = eff_busy[dec_src_a] |
                  eff_busy[dec_src_b] |
                  (WAW_EN & eff_busy[dec_dst]);

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic accept;

  assign in_ready = ~rst & ~flush_w & ~hazard & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    out_valid_d = out_valid_q;
    opcode_d    = opcode_q;
    rs_rt_d     = rs_rt_q;
    rwd_d       = rwd_q;
    instr_d     = instr_q;
    busy_d      = busy_q;
    stall_cnt_d = stall_cnt_q;

    if (flush_w) begin
      out_valid_d = 1'b0;
      busy_d      = '0;
    end else begin
      // Clears first, then the accepted destination, so a register set and
      // cleared in the same cycle ends up busy.
      busy_d = busy_q & ~clr_mask;
      if (accept && (dec_dst != 5'd0)) begin
        busy_d[dec_dst] = 1'b1;
      end
      out_valid_d = accept | (out_valid_q & ~out_ready);
    end
    busy_d[0] = 1'b0;

    if (accept) begin
      opcode_d = dec_op;
      rs_rt_d  = {dec_src_a, dec_src_b};
      rwd_d    = dec_dst;
      instr_d  = instr_in;
    end

    if (in_valid && hazard && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      rs_rt_q     <= '0;
      rwd_q       <= '0;
      instr_q     <= '0;
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      rs_rt_q     <= rs_rt_d;
      rwd_q       <= rwd_d;
      instr_q     <= instr_d;
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign out_valid = out_valid_q;
  assign opcode    = opcode_q;
  assign rs_rt     = rs_rt_q;
  assign rwd       = rwd_q;
  assign instr_out = instr_q;
  assign busy_vec  = busy_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_instr_decode_stage
//
// Bench for instr_decode_stage. A reference model of the scoreboard, the
// output valid flag and the stall counter is stepped once per cycle.
// Decoded results are queued when an accept is predicted and compared while
// the DUT holds them on its outputs. Directed scenarios are followed by a
// random phase. Build with +define+DECODE_FLUSH_EN to cover the flush port.
// ---------------------------------------------------------------------------
module tb_instr_decode_stage;

  localparam int WB_PORTS = 2;
  localparam int CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_JUMP = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_LDW  = 6'h23;
  localparam logic [5:0] OP_SDW  = 6'h2B;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                  flush = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [31:0]           instr_in = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [5:0]            opcode;
  logic [9:0]            rs_rt;
  logic [4:0]            rwd;
  logic [31:0]           instr_out;
  logic [WB_PORTS-1:0]   wb_valid = '0;
  logic [5*WB_PORTS-1:0] wb_addr = '0;
  logic [31:0]           busy_vec;
  logic [CNT_W-1:0]      stall_cnt;

  instr_decode_stage #(
    .WB_PORTS (WB_PORTS),
    .CNT_W    (CNT_W),
    .WAW_CHECK(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef DECODE_FLUSH_EN
    .flush    (flush),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .instr_in (instr_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .opcode   (opcode),
    .rs_rt    (rs_rt),
    .rwd      (rwd),
    .instr_out(instr_out),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .busy_vec (busy_vec),
    .stall_cnt(stall_cnt)
  );

  // ---------------- scoreboard / model state ----------------
  // entry = {opcode[52:47], src_a[46:42], src_b[41:37], dst[36:32], instr[31:0]}
  logic [52:0]      exp_q[$];
  logic [31:0]      m_busy;
  logic             m_ov;
  logic [CNT_W-1:0] m_cnt;
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] r25,
                                     input logic [4:0] r20, input logic [4:0] r15);
    return {op, r25, r20, r15, 11'h5A5};
  endfunction

  // Reference field decode.
  task automatic dec(input logic [31:0] ins, output logic [4:0] sa,
                     output logic [4:0] sb, output logic [4:0] d);
    logic [5:0] op;
    op = ins[31:26];
    sa = ins[20:16];
    if (op == OP_JUMP)                                      sb = 5'd0;
    else if (op == OP_SDW || op == OP_BEQ || op == OP_LDW)  sb = ins[25:21];
    else                                                    sb = ins[15:11];
    if (op == OP_SDW || op == OP_BEQ || op == OP_JUMP)      d = 5'd0;
    else                                                    d = ins[25:21];
  endtask

  // ---------------- driver tasks ----------------
  task automatic model_clear();
    m_busy = '0;
    m_ov   = 1'b0;
    m_cnt  = '0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  0);
    check("rst_opcode",    opcode,    0);
    check("rst_rs_rt",     rs_rt,     0);
    check("rst_rwd",       rwd,       0);
    check("rst_instr_out", instr_out, 0);
    check("rst_busy_vec",  busy_vec,  0);
    check("rst_stall_cnt", stall_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  // One clock cycle: compare DUT against the model with inputs stable,
  // predict accept, advance the model, then let the edge happen.
  task automatic step(output bit acc);
    logic [31:0] clr;
    logic [31:0] eb;
    logic [4:0]  sa, sb, d;
    logic [52:0] e;
    bit          hz, rdy, fl;
    @(negedge clk);
`ifdef DECODE_FLUSH_EN
    fl = flush;
`else
    fl = 1'b0;
`endif
    clr = '0;
    for (int i = 0; i < WB_PORTS; i++)
      if (wb_valid[i]) clr[wb_addr[5*i +: 5]] = 1'b1;
    eb = m_busy & ~clr;
    dec(instr_in, sa, sb, d);
    hz  = (sa != 0 && eb[sa]) || (sb != 0 && eb[sb]) || (d != 0 && eb[d]);
    rdy = !hz && (!m_ov || out_ready) && !fl;

    check("in_ready",  in_ready,  rdy);
    check("out_valid", out_valid, m_ov);
    check("busy_vec",  busy_vec,  m_busy);
    check("stall_cnt", stall_cnt, m_cnt);

    if (m_ov) begin
      if (exp_q.size() == 0) begin
        check("exp_q_empty", 1, 0);
      end else begin
        e = exp_q[0];
        check("opcode",    opcode,    e[52:47]);
        check("rs_rt",     rs_rt,     e[46:37]);
        check("rwd",       rwd,       e[36:32]);
        check("instr_out", instr_out, e[31:0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    if (fl) exp_q.delete();

    acc = in_valid && rdy;
    if (acc) exp_q.push_back({instr_in[31:26], sa, sb, d, instr_in});

    if (fl) begin
      m_busy = '0;
      m_ov   = 1'b0;
    end else begin
      m_busy = m_busy & ~clr;
      if (acc && d != 0) m_busy[d] = 1'b1;
      m_ov = acc || (m_ov && !out_ready);
    end
    m_busy[0] = 1'b0;
    if (in_valid && hz && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;

    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins);
    bit acc;
    int n;
    n = 0;
    in_valid = 1'b1;
    instr_in = ins;
    do begin
      step(acc);
      n++;
    end while (!acc && n < 40);
    if (!acc) check("issue_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic clear_all();
    bit acc;
    for (int r = 0; r < 16; r++) begin
      wb_valid = 2'b11;
      wb_addr  = {5'(2*r + 1), 5'(2*r)};
      step(acc);
    end
    wb_valid = '0;
  endtask

  task automatic build_stall();
    bit acc;
    out_ready = 1'b1;
    issue(mk(OP_ADD, 5'd3, 5'd0, 5'd0));
    issue(mk(OP_ADD, 5'd4, 5'd0, 5'd0));
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr_in  = mk(OP_ADD, 5'd6, 5'd0, 5'd3);
    repeat (9) step(acc);
    check("stall_busy_18", busy_vec, 32'h18);
    check("stall_cnt_9",   stall_cnt, 9);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit          acc;
    logic [31:0] j1, j2;
    model_clear();
    do_reset();

    // LDW: dst 3, src 1
    out_ready = 1'b1;
    issue(mk(OP_LDW, 5'd3, 5'd1, 5'd7));
    check("t1_out_valid", out_valid, 1);
    check("t1_rwd",       rwd, 3);
    check("t1_rs_rt",     rs_rt, {5'd1, 5'd3});
    check("t1_busy",      busy_vec, 32'h8);

    // ADD dst 4 reading r3: stalls until write-back of r3, bypass on that cycle
    in_valid = 1'b1;
    instr_in = mk(OP_ADD, 5'd4, 5'd0, 5'd3);
    repeat (3) begin
      step(acc);
      check("t2_stalled", acc, 0);
    end
    check("t2_stall_cnt", stall_cnt, 3);
    wb_valid = 2'b01;
    wb_addr  = {5'd0, 5'd3};
    step(acc);
    check("t2_bypass_accept", acc, 1);
    wb_valid = '0;
    in_valid = 1'b0;
    step(acc);

    // Back-to-back JUMPs with execute stalled for 3 cycles
    j1 = mk(OP_JUMP, 5'd9, 5'd0, 5'd6);
    j2 = mk(OP_JUMP, 5'd11, 5'd0, 5'd2);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr_in  = j1;
    step(acc);
    check("t3_j1_accept", acc, 1);
    instr_in = j2;
    repeat (3) begin
      step(acc);
      check("t3_j2_blocked", acc, 0);
    end
    check("t3_hold_instr", instr_out, j1);
    out_ready = 1'b1;
    step(acc);
    check("t3_j2_accept", acc, 1);
    in_valid = 1'b0;
    check("t3_j2_out",   instr_out, j2);
    check("t3_srcb_0",   rs_rt[4:0], 0);
    check("t3_busy",     busy_vec, 32'h10);
    step(acc);

    // Set and clear of r5 in the same cycle: set wins
    wb_valid = 2'b10;
    wb_addr  = {5'd5, 5'd0};
    issue(mk(OP_ADD, 5'd5, 5'd0, 5'd0));
    wb_valid = '0;
    check("t4_busy5_set", busy_vec[5], 1);
    issue(mk(OP_ADD, 5'd7, 5'd0, 5'd0));
    check("t4_busy7_set", busy_vec[7], 1);
    wb_valid = 2'b11;
    wb_addr  = {5'd7, 5'd7};
    step(acc);
    wb_valid = '0;
    check("t4_busy7_clr", busy_vec[7], 0);
    check("t4_busy5_kept", busy_vec[5], 1);

    // Fill scoreboard, then an all-register-0 op must still issue at once
    clear_all();
    for (int r = 1; r < 32; r++) issue(mk(OP_ADD, 5'(r), 5'd0, 5'd0));
    check("t5_busy_full", busy_vec, 32'hFFFF_FFFE);
    in_valid = 1'b1;
    instr_in = 32'h0;
    step(acc);
    check("t5_zero_regs_issue", acc, 1);
    in_valid = 1'b0;
    step(acc);

    // Reset in the middle of a stall
    do_reset();
    build_stall();
    check("t6_out_valid_held", out_valid, 1);
    in_valid = 1'b0;
    do_reset();
    out_ready = 1'b1;
    step(acc);

`ifdef DECODE_FLUSH_EN
    // Flush: drops held op and scoreboard, stall counter keeps its value
    build_stall();
    in_valid = 1'b0;
    flush    = 1'b1;
    step(acc);
    flush = 1'b0;
    check("fl_out_valid", out_valid, 0);
    check("fl_busy",      busy_vec, 0);
    check("fl_stall_cnt", stall_cnt, 9);
    out_ready = 1'b1;
    step(acc);
    do_reset();
`endif

    // Stall counter saturation
    out_ready = 1'b1;
    issue(mk(OP_LDW, 5'd3, 5'd0, 5'd0));
    in_valid = 1'b1;
    instr_in = mk(OP_SDW, 5'd3, 5'd2, 5'd0);
    repeat (20) step(acc);
    check("sat_stall_cnt", stall_cnt, CNT_MAX);
    wb_valid = 2'b01;
    wb_addr  = {5'd0, 5'd3};
    step(acc);
    check("sat_release", acc, 1);
    wb_valid = '0;
    in_valid = 1'b0;
    step(acc);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      case ($urandom_range(0, 4))
        0:       op = OP_ADD;
        1:       op = OP_LDW;
        2:       op = OP_SDW;
        3:       op = OP_BEQ;
        default: op = OP_JUMP;
      endcase
      in_valid  = ($urandom_range(0, 9) < 7);
      instr_in  = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 11'($urandom_range(0, 2047))};
      out_ready = ($urandom_range(0, 3) != 0);
      wb_valid  = 2'($urandom_range(0, 3));
      wb_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
`ifdef DECODE_FLUSH_EN
      flush     = ($urandom_range(0, 29) == 0);
`endif
      step(acc);
    end
    in_valid  = 1'b0;
    wb_valid  = '0;
    out_ready = 1'b1;
    flush     = 1'b0;
    repeat (2) step(acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
